// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: holds the decoded one-hot line for HOLD_CYCLES cycles,
// then pulses done. A scan request walks all eight lines in order.
module decoder_3to8_seq #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       in_valid,
   input  logic [2:0] in_code,
   output logic       in_ready,
   input  logic       scan_start,
   output logic [7:0] y,
   output logic       out_valid,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [2:0]       idx;
   logic [2:0]       idx_nx;
   logic [7:0]       y_nx;
   logic             done_nx;

   // State and registered outputs; reset clears everything, no done on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         y         <= 8'h00;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         idx       <= idx_nx;
         y         <= y_nx;
         out_valid <= |y_nx;
         busy      <= (state_nx != IDLE);
         done      <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      y_nx     = y;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            y_nx = 8'h00;
            // Scan has priority over a presented code.
            if (enable && scan_start) begin
               y_nx     = 8'h01;
               idx_nx   = 3'd0;
               cnt_nx   = RELOAD;
               state_nx = SCAN;
            end else if (in_valid && in_ready) begin
               y_nx     = 8'h01 << in_code;
               cnt_nx   = RELOAD;
               state_nx = HOLD;
            end
         end
         HOLD: begin
            if (!enable) begin
               y_nx     = 8'h00;
               cnt_nx   = '0;
               idx_nx   = 3'd0;
               state_nx = IDLE;
            end else if (cnt != '0) begin
               cnt_nx = cnt - 1'b1;
            end else begin
               y_nx     = 8'h00;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         SCAN: begin
            if (!enable) begin
               y_nx     = 8'h00;
               cnt_nx   = '0;
               idx_nx   = 3'd0;
               state_nx = IDLE;
            end else if (cnt != '0) begin
               cnt_nx = cnt - 1'b1;
            end else if (idx != 3'd7) begin
               idx_nx = idx + 3'd1;
               y_nx   = y << 1;
               cnt_nx = RELOAD;
            end else begin
               y_nx     = 8'h00;
               idx_nx   = 3'd0;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: begin
            y_nx     = 8'h00;
            cnt_nx   = '0;
            idx_nx   = 3'd0;
            state_nx = IDLE;
         end
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE) && enable && !scan_start;
   end

endmodule

// File: doc/decoder_3to8_seq.md
Name: decoder_3to8_seq

Overview:
Sequenced 3-to-8 decoder, the inverse of the team's 8-to-3 encoder. It accepts a 3-bit code through a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles, then reports completion. A scan mode walks all eight lines in order, for use in strobe or select generation, LED/column scanning and encoder loopback tests.

Parameters:
HOLD_CYCLES, 4, cycles each one-hot output is held; legal range 1..255
CNT_W, 8, width of the internal hold counter; must hold HOLD_CYCLES-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  block enable; deassertion aborts any operation
in_valid  input  1  in_code is presented
in_code  input  3  code to decode, 0..7
in_ready  output  1  combinational: (state==IDLE) & enable & ~scan_start
scan_start  input  1  request a full 0..7 scan; sampled only in IDLE
y  output  8  registered one-hot output, or 8'h00 when inactive
out_valid  output  1  registered; equals (y != 0)
busy  output  1  registered; 1 when state is HOLD or SCAN
done  output  1  registered single-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE, y=8'h00, out_valid=0, busy=0, done=0, counter=0, scan index=0. Reset takes effect immediately, including mid-operation; there is no done on reset.
- States: IDLE, HOLD, SCAN. Registered outputs and counter update on the rising edge of clk.
- IDLE:
  - If enable & scan_start: y<=8'h01, index<=0, cnt<=HOLD_CYCLES-1, go to SCAN. scan_start has priority over in_valid, and in_ready is low that cycle.
  - Else if in_valid & in_ready: y<=(8'h01 << in_code), cnt<=HOLD_CYCLES-1, go to HOLD.
  - Otherwise y stays 8'h00.
- HOLD:
  - If cnt!=0: cnt<=cnt-1 and y is unchanged.
  - If cnt==0: y<=0, done<=1 for one cycle, go to IDLE.
  - in_valid and scan_start are ignored (in_ready=0).
- SCAN:
  - Each line is held for HOLD_CYCLES cycles, and cnt reloads on each step.
  - At cnt==0 with index<7: index<=index+1, y<=y<<1.
  - At cnt==0 with index==7: y<=0, done<=1, go to IDLE.
- Latency: handshake at edge N puts y valid from edge N through edge N+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles. done is high in the cycle after the last hold cycle, alongside y=0 and busy=0.
- Back-to-back: in_ready is high in the done cycle, so a new code can be accepted there. The minimum gap between pulses is one cycle with y=0.
- Scan duration: 8*HOLD_CYCLES cycles with y nonzero, followed by done.
- Abort: if enable=0 in HOLD or SCAN, next edge sets y<=0, busy<=0, state<=IDLE, done stays 0, counter and index are cleared.
- HOLD_CYCLES=1: each line is high for exactly one cycle.
- y is always one-hot or zero, never multi-hot; out_valid == |y at all times.
- All 3-bit codes are legal, so there is no default/error case.
- done never coincides with y!=0.

Test Plan:
- Reset with rst_n=0 mid-HOLD (code 5): y=8'h00, busy=0, done=0 asynchronously. After release, in_ready=1 once enable=1.
- HOLD_CYCLES=4, in_code=3 handshake at edge N: y=8'h08 for edges N..N+3, done=1 and y=0 in the cycle after, busy high exactly 4 cycles.
- Sweep codes 0..7 back-to-back with in_valid held high: y=8'h01,02,04,...,80, each for 4 cycles, one y=0/done cycle between each. A loopback through encoder_8to3 must return the original code.
- scan_start=1 and in_valid=1 (code 6) in the same IDLE cycle: SCAN wins, in_ready=0, y steps 01→02→…→80 at 4 cycles each (32 cycles), then a single done.
- enable dropped during the third line of a scan (y=8'h04): next cycle y=0, busy=0, no done. Re-enable with code 1 gives y=8'h02 normally.
- HOLD_CYCLES=1 build, code 7: y=8'h80 for exactly 1 cycle, done next cycle. in_valid during HOLD is not accepted (in_ready=0).
